// File: rtl/regfile_param_if.sv
// Bus bundle for the decode-stage register file: read/write/clear requests
// from the pipeline and read data plus sweep status back.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic                  CLR;
  logic [ADDR_W-1:0]     A1;
  logic [ADDR_W-1:0]     A2;
  logic [ADDR_W-1:0]     A3;
  logic [DATA_W-1:0]     WD3;
  logic                  WE3;
  logic [DATA_W/8-1:0]   BE3;
  logic [DATA_W-1:0]     RD1;
  logic [DATA_W-1:0]     RD2;
  logic                  BUSY;

  modport master (
    output CLR, A1, A2, A3, WD3, WE3, BE3,
    input  RD1, RD2, BUSY
  );

  modport slave (
    input  CLR, A1, A2, A3, WD3, WE3, BE3,
    output RD1, RD2, BUSY
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2-read/1-write register file with byte enables, optional zero
// register, optional write-to-read bypass and a sequential clear sweep.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1
) (
  input  logic           CLK,
  input  logic           rst,
  regfile_param_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   ptr_reg, ptr_next;
  logic                busy;
  logic                wr_en;
  logic                clr_en;
  logic [DATA_W-1:0]   rd1_raw;
  logic [DATA_W-1:0]   rd2_raw;

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_reg <= CLEAR;
      ptr_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
    end
  end

  // CLR is only accepted from IDLE; a sweep in progress always runs to the end.
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    case (state_reg)
      IDLE: begin
        if (bus.CLR) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        if (ptr_reg == ADDR_W'(DEPTH - 1)) begin
          state_next = IDLE;
          ptr_next   = '0;
        end else begin
          ptr_next = ptr_reg + ADDR_W'(1);
        end
      end
      default: begin
        state_next = CLEAR;
        ptr_next   = '0;
      end
    endcase
  end

  assign busy   = (state_reg == CLEAR);
  assign clr_en = busy && !rst;
  // A write is effective only when idle, not being cleared, and not aimed at a hardwired zero entry.
  assign wr_en  = (state_reg == IDLE) && !rst && !bus.CLR && bus.WE3 &&
                  !(ZERO_REG && (bus.A3 == '0));

  // One byte-wide memory per lane so byte enables map onto independent RAM write ports.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      logic [7:0] mem [DEPTH];
      logic [7:0] wd_b;
      logic       byp1;
      logic       byp2;

      assign wd_b = bus.WD3[8*gi +: 8];

      always_ff @(posedge CLK) begin
        if (clr_en) begin
          mem[ptr_reg] <= '0;
        end else if (wr_en && bus.BE3[gi]) begin
          mem[bus.A3] <= wd_b;
        end
      end

      assign byp1 = BYPASS && wr_en && bus.BE3[gi] && (bus.A3 == bus.A1);
      assign byp2 = BYPASS && wr_en && bus.BE3[gi] && (bus.A3 == bus.A2);

      assign rd1_raw[8*gi +: 8] = byp1 ? wd_b : mem[bus.A1];
      assign rd2_raw[8*gi +: 8] = byp2 ? wd_b : mem[bus.A2];
    end
  endgenerate

  assign bus.BUSY = busy;
  assign bus.RD1  = (busy || (ZERO_REG && (bus.A1 == '0))) ? '0 : rd1_raw;
  assign bus.RD2  = (busy || (ZERO_REG && (bus.A2 == '0))) ? '0 : rd2_raw;
endmodule

// File: tb/tb_regfile_param.sv
// Directed bench driving two builds side by side: A (zero reg + bypass) and
// B (ordinary entry 0, no bypass) with identical stimulus.
module tb_regfile_param;
  logic CLK;
  logic rst;
  int   checks;
  int   errors;

  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ia ();
  regfile_param_if #(.DATA_W(32), .ADDR_W(5)) ib ();

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_a (
    .CLK (CLK),
    .rst (rst),
    .bus (ia)
  );

  regfile_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1'b0), .BYPASS(1'b0)) u_b (
    .CLK (CLK),
    .rst (rst),
    .bus (ib)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        we;
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [3:0]  be;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [31:0] a_rd1;
    logic [31:0] a_rd2;
    logic [31:0] b_rd1;
    logic [31:0] b_rd2;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [4:0] a3, input logic [31:0] wd,
                       input logic [3:0] be, input logic [4:0] a1, input logic [4:0] a2,
                       input logic clr);
    ia.WE3 = we; ia.A3 = a3; ia.WD3 = wd; ia.BE3 = be; ia.A1 = a1; ia.A2 = a2; ia.CLR = clr;
    ib.WE3 = we; ib.A3 = a3; ib.WD3 = wd; ib.BE3 = be; ib.A1 = a1; ib.A2 = a2; ib.CLR = clr;
  endtask

  // Counts further negedges on which BUSY is seen high; bounded so a stuck sweep cannot hang.
  task automatic count_busy(output int ca, output int cb);
    ca = 0;
    cb = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge CLK);
      ia.CLR = 1'b0;
      ib.CLR = 1'b0;
      #1;
      if (ia.BUSY === 1'b1) ca++;
      if (ib.BUSY === 1'b1) cb++;
      if (ia.BUSY !== 1'b1 && ib.BUSY !== 1'b1) break;
    end
  endtask

  initial begin
    int ca, cb, pa, pb;
    checks = 0;
    errors = 0;

    vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'h0, 32'h0};
    vecs[1] = '{1'b1, 5'd0, 32'h12345678, 4'hF, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b1, 5'd7, 32'h11223344, 4'hF, 5'd0, 5'd5, 32'h0, 32'hDEADBEEF, 32'h12345678, 32'hDEADBEEF};
    vecs[3] = '{1'b1, 5'd7, 32'hAABBCCDD, 4'h5, 5'd7, 5'd7, 32'h11BB33DD, 32'h11BB33DD, 32'h11223344, 32'h11223344};
    vecs[4] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd7, 5'd0, 32'h11BB33DD, 32'h0, 32'h11BB33DD, 32'h12345678};
    vecs[5] = '{1'b1, 5'd9, 32'h0000CAFE, 4'hF, 5'd9, 5'd9, 32'h0000CAFE, 32'h0000CAFE, 32'h0, 32'h0};
    vecs[6] = '{1'b1, 5'd9, 32'hFFFFFFFF, 4'h0, 5'd9, 5'd7, 32'h0000CAFE, 32'h11BB33DD, 32'h0000CAFE, 32'h11BB33DD};
    vecs[7] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd9, 5'd0, 32'h0000CAFE, 32'h0, 32'h0000CAFE, 32'h12345678};
    vecs[8] = '{1'b1, 5'd0, 32'hFFFFFFFF, 4'h2, 5'd0, 5'd0, 32'h0, 32'h0, 32'h12345678, 32'h12345678};
    vecs[9] = '{1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h1234FF78, 32'h1234FF78};

    // Reset held two cycles, then the sweep must take exactly 32 cycles.
    rst = 1'b1;
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0);
    repeat (2) @(negedge CLK);
    #1;
    check("busy_in_rst_a", 32'(ia.BUSY), 32'd1);
    check("busy_in_rst_b", 32'(ib.BUSY), 32'd1);
    @(negedge CLK);
    rst = 1'b0;
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd4, 5'd4, 1'b0);
    #1;
    check("rd1_busy_a", ia.RD1, 32'h0);
    check("rd1_busy_b", ib.RD1, 32'h0);
    pa = (ia.BUSY === 1'b1) ? 1 : 0;
    pb = (ib.BUSY === 1'b1) ? 1 : 0;
    count_busy(ca, cb);
    check("rst_sweep_len_a", 32'(pa + ca), 32'd32);
    check("rst_sweep_len_b", 32'(pb + cb), 32'd32);
    $display("reset sweep: busy cycles a=%0d b=%0d", pa + ca, pb + cb);

    for (int i = 0; i < 32; i++) begin
      @(negedge CLK);
      drive(1'b0, 5'd0, 32'h0, 4'h0, 5'(i), 5'(31 - i), 1'b0);
      #1;
      check("clear_rd1_a", ia.RD1, 32'h0);
      check("clear_rd2_a", ia.RD2, 32'h0);
      check("clear_rd1_b", ib.RD1, 32'h0);
      check("clear_rd2_b", ib.RD2, 32'h0);
    end
    $display("post-reset readback of 32 entries done");

    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      drive(vecs[i].we, vecs[i].a3, vecs[i].wd, vecs[i].be, vecs[i].a1, vecs[i].a2, 1'b0);
      #1;
      check($sformatf("vec%0d_rd1_a", i), ia.RD1, vecs[i].a_rd1);
      check($sformatf("vec%0d_rd2_a", i), ia.RD2, vecs[i].a_rd2);
      check($sformatf("vec%0d_rd1_b", i), ib.RD1, vecs[i].b_rd1);
      check($sformatf("vec%0d_rd2_b", i), ib.RD2, vecs[i].b_rd2);
      check($sformatf("vec%0d_busy", i), 32'({ia.BUSY, ib.BUSY}), 32'd0);
      $display("vec %0d: we=%b a3=%0d wd=%h be=%h a1=%0d a2=%0d rd1a=%h rd2a=%h rd1b=%h rd2b=%h",
               i, vecs[i].we, vecs[i].a3, vecs[i].wd, vecs[i].be, vecs[i].a1, vecs[i].a2,
               ia.RD1, ia.RD2, ib.RD1, ib.RD2);
    end

    // CLR with a simultaneous write: write dropped, no bypass, CLR mid-sweep ignored.
    @(negedge CLK);
    drive(1'b1, 5'd3, 32'h55555555, 4'hF, 5'd3, 5'd7, 1'b1);
    #1;
    check("clr_cycle_rd1_a", ia.RD1, 32'h0);
    check("clr_cycle_rd2_a", ia.RD2, 32'h11BB33DD);
    check("clr_cycle_busy", 32'(ia.BUSY), 32'd0);
    pa = 0;
    pb = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      drive(1'b1, 5'd3, 32'h66666666, 4'hF, 5'd3, 5'd3, (i == 3));
      #1;
      if (ia.BUSY === 1'b1) pa++;
      if (ib.BUSY === 1'b1) pb++;
    end
    check("clr_busy_rd1_a", ia.RD1, 32'h0);
    check("clr_busy_rd2_b", ib.RD2, 32'h0);
    count_busy(ca, cb);
    check("clr_sweep_len_a", 32'(pa + ca), 32'd32);
    check("clr_sweep_len_b", 32'(pb + cb), 32'd32);
    $display("clr sweep: busy cycles a=%0d b=%0d", pa + ca, pb + cb);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd3, 5'd7, 1'b0);
    #1;
    check("after_clr_r3_a", ia.RD1, 32'h0);
    check("after_clr_r3_b", ib.RD1, 32'h0);
    check("after_clr_r7_a", ia.RD2, 32'h0);
    check("after_clr_r7_b", ib.RD2, 32'h0);

    // Entry 0 holds data only in the build without the zero register.
    @(negedge CLK);
    drive(1'b1, 5'd0, 32'hA5A5A5A5, 4'hF, 5'd0, 5'd0, 1'b0);
    @(negedge CLK);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0);
    #1;
    check("r0_data_a", ia.RD1, 32'h0);
    check("r0_data_b", ib.RD1, 32'hA5A5A5A5);
    $display("entry 0 after write: a=%h b=%h", ia.RD1, ib.RD1);

    // Reset arriving at sweep cycle 10 restarts the full sweep.
    @(negedge CLK);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd0, 1'b0);
    end
    rst = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    check("busy_mid_rst_a", 32'(ia.BUSY), 32'd1);
    check("busy_mid_rst_b", 32'(ib.BUSY), 32'd1);
    rst = 1'b0;
    #1;
    pa = (ia.BUSY === 1'b1) ? 1 : 0;
    pb = (ib.BUSY === 1'b1) ? 1 : 0;
    count_busy(ca, cb);
    check("restart_len_a", 32'(pa + ca), 32'd32);
    check("restart_len_b", 32'(pb + cb), 32'd32);
    $display("restarted sweep: busy cycles a=%0d b=%0d", pa + ca, pb + cb);
    drive(1'b0, 5'd0, 32'h0, 4'h0, 5'd0, 5'd31, 1'b0);
    #1;
    check("restart_r0_b", ib.RD1, 32'h0);
    check("restart_r31_b", ib.RD2, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
